lap_stopwatch: RTL and testbench

LAP_STOPWATCH -- requirements
Module: lap_stopwatch

---
 rtl/stopwatch_pkg.sv | 47 ++++
 rtl/bcd_digit.sv | 63 ++++++
 rtl/lap_stopwatch.sv | 215 +++++++++++++++++++++
 tb/tb_lap_stopwatch.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared definitions for the lap stopwatch: state encoding, digit moduli,
// the BCD time record and the seven-segment lookup.
package stopwatch_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_PAUSE = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam int unsigned MOD_TENTHS = 10;
    localparam int unsigned MOD_SECS   = 10;
    localparam int unsigned MOD_TENS   = 6;

    localparam logic [6:0] SEG_ZERO  = 7'h40;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef struct packed {
        logic [3:0] min;
        logic [3:0] tens;
        logic [3:0] secs;
        logic [3:0] tenths;
    } bcd_time_t;

    // Segment order {g,f,e,d,c,b,a}, active-low; non-BCD codes blank the digit.
    function automatic logic [6:0] bcd_to_seg(input logic [3:0] bcd);
        logic [6:0] seg;
        case (bcd)
            4'd0:    seg = 7'h40;
            4'd1:    seg = 7'h79;
            4'd2:    seg = 7'h24;
            4'd3:    seg = 7'h30;
            4'd4:    seg = 7'h19;
            4'd5:    seg = 7'h12;
            4'd6:    seg = 7'h02;
            4'd7:    seg = 7'h78;
            4'd8:    seg = 7'h00;
            4'd9:    seg = 7'h10;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

    function automatic logic [3:0] sat_bcd(input logic [3:0] v, input logic [3:0] lim);
        return (v > lim) ? lim : v;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One decade of the count chain: modulus-MOD up/down counter with synchronous
// load and a carry/borrow out that lets the next digit step in the same cycle.
module bcd_digit #(
    parameter int unsigned MOD = 10
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       load_i,
    input  logic [3:0] load_val_i,
    input  logic       en_i,
    input  logic       down_i,
    output logic [3:0] q_o,
    output logic [3:0] nxt_o,
    output logic       co_o
);

    localparam logic [3:0] TOP = 4'(MOD - 1);

    generate
        if (MOD < 2 || MOD > 16) begin : g_bad_mod
            $error("bcd_digit: MOD must be in 2..16");
        end
    endgenerate

    logic [3:0] val_q;
    logic [3:0] val_d;

    always_comb begin
        val_d = val_q;
        co_o  = 1'b0;
        if (load_i) begin
            val_d = load_val_i;
        end else if (en_i) begin
            if (down_i) begin
                if (val_q == 4'd0) begin
                    val_d = TOP;
                    co_o  = 1'b1;
                end else begin
                    val_d = val_q - 4'd1;
                end
            end else begin
                if (val_q == TOP) begin
                    val_d = 4'd0;
                    co_o  = 1'b1;
                end else begin
                    val_d = val_q + 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            val_q <= 4'd0;
        end else begin
            val_q <= val_d;
        end
    end

    assign q_o   = val_q;
    assign nxt_o = val_d;

endmodule

// File: rtl/lap_stopwatch.sv
// Tenths-resolution up/down stopwatch with lap hold and a 4-digit multiplexed
// seven-segment driver.
//
//   state    | meaning
//   ---------+----------------------------------------------------------
//   ST_IDLE  | count cleared, waiting for start_stop
//   ST_RUN   | divider running, count steps on every tick
//   ST_PAUSE | divider and count frozen, residue kept for resume
//   ST_DONE  | terminal value reached and held until clear
module lap_stopwatch
    import stopwatch_pkg::*;
#(
    parameter int unsigned CLK_HZ  = 100_000_000,
    parameter int unsigned TICK_HZ = 10,
    parameter int unsigned SCAN_HZ = 2000,
    parameter int unsigned MAX_MIN = 9
) (
    input  logic        clk_100MHz,
    input  logic        reset,
    input  logic        start_stop,
    input  logic        lap,
    input  logic        clear,
    input  logic        dir,
    input  logic [15:0] preset,
    output logic [15:0] digits,
    output logic [6:0]  digit_cathodes,
    output logic [7:0]  digit_anodes,
    output logic        running,
    output logic        done
);

    generate
        if (CLK_HZ % TICK_HZ != 0) begin : g_bad_tick
            $error("lap_stopwatch: CLK_HZ must be a multiple of TICK_HZ");
        end
        if (CLK_HZ % SCAN_HZ != 0) begin : g_bad_scan
            $error("lap_stopwatch: CLK_HZ must be a multiple of SCAN_HZ");
        end
        if (MAX_MIN < 1 || MAX_MIN > 9) begin : g_bad_max
            $error("lap_stopwatch: MAX_MIN must be in 1..9");
        end
    endgenerate

    localparam int unsigned TICK_DIV  = CLK_HZ / TICK_HZ;
    localparam int unsigned SCAN_DIV  = CLK_HZ / SCAN_HZ;
    localparam int unsigned TW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned SW        = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
    localparam logic [3:0]    MAX_BCD   = 4'(MAX_MIN);

    // Assertion is immediate; release is retimed through two flops.
    logic rst_meta_q;
    logic rst_n_q;

    always_ff @(posedge clk_100MHz or negedge reset) begin
        if (!reset) begin
            rst_meta_q <= 1'b0;
            rst_n_q    <= 1'b0;
        end else begin
            rst_meta_q <= 1'b1;
            rst_n_q    <= rst_meta_q;
        end
    end

    logic [1:0]    state_q, state_d;
    logic          dir_q, dir_d;
    logic          lap_q, lap_d;
    logic [TW-1:0] tick_cnt_q, tick_cnt_d;
    logic          tick;
    bcd_time_t     count_q, count_nxt, snap_q, snap_d;
    bcd_time_t     preset_sat, start_val, term_val, cnt_load_val;
    logic          cnt_load;
    logic [3:0]    co;

    assign preset_sat = {sat_bcd(preset[15:12], MAX_BCD),
                         sat_bcd(preset[11:8], 4'd5),
                         sat_bcd(preset[7:4], 4'd9),
                         sat_bcd(preset[3:0], 4'd9)};
    assign start_val  = dir ? preset_sat : '0;
    assign term_val   = dir_q ? '0 : {MAX_BCD, 4'd5, 4'd9, 4'd9};
    assign tick       = (state_q == ST_RUN) && (tick_cnt_q == TICK_LAST);

    bcd_digit #(.MOD(MOD_TENTHS)) u_tenths (
        .clk_i(clk_100MHz), .rst_n_i(rst_n_q), .load_i(cnt_load),
        .load_val_i(cnt_load_val.tenths), .en_i(tick), .down_i(dir_q),
        .q_o(count_q.tenths), .nxt_o(count_nxt.tenths), .co_o(co[0])
    );

    bcd_digit #(.MOD(MOD_SECS)) u_secs (
        .clk_i(clk_100MHz), .rst_n_i(rst_n_q), .load_i(cnt_load),
        .load_val_i(cnt_load_val.secs), .en_i(co[0]), .down_i(dir_q),
        .q_o(count_q.secs), .nxt_o(count_nxt.secs), .co_o(co[1])
    );

    bcd_digit #(.MOD(MOD_TENS)) u_tens (
        .clk_i(clk_100MHz), .rst_n_i(rst_n_q), .load_i(cnt_load),
        .load_val_i(cnt_load_val.tens), .en_i(co[1]), .down_i(dir_q),
        .q_o(count_q.tens), .nxt_o(count_nxt.tens), .co_o(co[2])
    );

    bcd_digit #(.MOD(MAX_MIN + 1)) u_min (
        .clk_i(clk_100MHz), .rst_n_i(rst_n_q), .load_i(cnt_load),
        .load_val_i(cnt_load_val.min), .en_i(co[2]), .down_i(dir_q),
        .q_o(count_q.min), .nxt_o(count_nxt.min), .co_o(co[3])
    );

    // Terminal detection looks at the post-tick value so DONE lands on the same edge.
    always_comb begin
        state_d      = state_q;
        dir_d        = dir_q;
        lap_d        = lap_q;
        tick_cnt_d   = tick_cnt_q;
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        if (clear) begin
            state_d    = ST_IDLE;
            lap_d      = 1'b0;
            tick_cnt_d = '0;
            cnt_load   = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_stop) begin
                        tick_cnt_d   = '0;
                        dir_d        = dir;
                        cnt_load     = 1'b1;
                        cnt_load_val = start_val;
                        state_d      = (dir && start_val == '0) ? ST_DONE : ST_RUN;
                    end
                end
                ST_RUN: begin
                    tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
                    if (tick && count_nxt == term_val) begin
                        state_d = ST_DONE;
                        lap_d   = 1'b0;
                    end else begin
                        if (start_stop) state_d = ST_PAUSE;
                        if (lap)        lap_d   = !lap_q;
                    end
                end
                ST_PAUSE: begin
                    if (start_stop) state_d = ST_RUN;
                    if (lap)        lap_d   = !lap_q;
                end
                default: begin
                end
            endcase
        end
    end

    assign snap_d = (lap_d && !lap_q) ? count_q : snap_q;

    always_ff @(posedge clk_100MHz or negedge rst_n_q) begin
        if (!rst_n_q) begin
            state_q    <= ST_IDLE;
            dir_q      <= 1'b0;
            lap_q      <= 1'b0;
            tick_cnt_q <= '0;
            snap_q     <= '0;
        end else begin
            state_q    <= state_d;
            dir_q      <= dir_d;
            lap_q      <= lap_d;
            tick_cnt_q <= tick_cnt_d;
            snap_q     <= snap_d;
        end
    end

    logic [SW-1:0] scan_cnt_q, scan_cnt_d;
    logic [1:0]    scan_idx_q, scan_idx_d;
    logic          scan_adv;
    bcd_time_t     disp;
    logic [3:0]    disp_digit;
    logic [7:0]    anode_q, anode_d;
    logic [6:0]    cath_q, cath_d;

    assign scan_adv   = (scan_cnt_q == SCAN_LAST);
    assign scan_cnt_d = scan_adv ? '0 : scan_cnt_q + 1'b1;
    assign scan_idx_d = scan_idx_q + {1'b0, scan_adv};
    assign disp       = lap_q ? snap_q : count_q;

    // Anodes and cathodes both come from the next index so they switch on the same edge.
    always_comb begin
        case (scan_idx_d)
            2'd0:    disp_digit = disp.tenths;
            2'd1:    disp_digit = disp.secs;
            2'd2:    disp_digit = disp.tens;
            default: disp_digit = disp.min;
        endcase
        anode_d = {4'hF, ~(4'b0001 << scan_idx_d)};
        cath_d  = bcd_to_seg(disp_digit);
    end

    always_ff @(posedge clk_100MHz or negedge rst_n_q) begin
        if (!rst_n_q) begin
            scan_cnt_q <= '0;
            scan_idx_q <= 2'd0;
            anode_q    <= 8'hFE;
            cath_q     <= SEG_ZERO;
        end else begin
            scan_cnt_q <= scan_cnt_d;
            scan_idx_q <= scan_idx_d;
            anode_q    <= anode_d;
            cath_q     <= cath_d;
        end
    end

    assign digits         = count_q;
    assign digit_anodes   = anode_q;
    assign digit_cathodes = cath_q;
    assign running        = (state_q == ST_RUN);
    assign done           = (state_q == ST_DONE);

endmodule

// File: tb/tb_lap_stopwatch.sv
// Scoreboard bench for lap_stopwatch at 100 Hz clock, 10 Hz tick, 50 Hz scan.
module tb_lap_stopwatch;

    logic        clk_100MHz = 1'b0;
    logic        reset;
    logic        start_stop, lap, clear, dir;
    logic [15:0] preset;

    logic [15:0] digits, d1_digits;
    logic [6:0]  digit_cathodes, d1_cathodes;
    logic [7:0]  digit_anodes, d1_anodes;
    logic        running, done, d1_running, d1_done;

    always #5 clk_100MHz = ~clk_100MHz;

    lap_stopwatch #(.CLK_HZ(100), .TICK_HZ(10), .SCAN_HZ(50), .MAX_MIN(9)) dut (
        .clk_100MHz(clk_100MHz), .reset(reset), .start_stop(start_stop), .lap(lap),
        .clear(clear), .dir(dir), .preset(preset), .digits(digits),
        .digit_cathodes(digit_cathodes), .digit_anodes(digit_anodes),
        .running(running), .done(done)
    );

    lap_stopwatch #(.CLK_HZ(100), .TICK_HZ(10), .SCAN_HZ(50), .MAX_MIN(1)) dut1 (
        .clk_100MHz(clk_100MHz), .reset(reset), .start_stop(start_stop), .lap(lap),
        .clear(clear), .dir(dir), .preset(preset), .digits(d1_digits),
        .digit_cathodes(d1_cathodes), .digit_anodes(d1_anodes),
        .running(d1_running), .done(d1_done)
    );

    localparam int S_DIG = 0, S_RUN = 1, S_DONE = 2, S_AN = 3, S_CA = 4;
    localparam int S_D1DIG = 5, S_D1DONE = 6, S_D1RUN = 7, S_D1AN = 8, S_D1CA = 9;
    localparam int P_SS = 0, P_LAP = 1, P_CLR = 2, P_CLR_LAP = 3;

    typedef struct {
        string       tag;
        int          sel;
        int          due;
        logic [15:0] exp;
    } exp_t;

    exp_t sb_q[$];
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;

    always @(posedge clk_100MHz) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [15:0] observe(input int sel);
        case (sel)
            S_DIG:    return digits;
            S_RUN:    return {15'h0, running};
            S_DONE:   return {15'h0, done};
            S_AN:     return {8'h0, digit_anodes};
            S_CA:     return {9'h0, digit_cathodes};
            S_D1DIG:  return d1_digits;
            S_D1DONE: return {15'h0, d1_done};
            S_D1RUN:  return {15'h0, d1_running};
            S_D1AN:   return {8'h0, d1_anodes};
            default:  return {9'h0, d1_cathodes};
        endcase
    endfunction

    function automatic logic [6:0] seg(input logic [3:0] d);
        case (d)
            4'd0: return 7'b1000000;
            4'd1: return 7'b1111001;
            4'd2: return 7'b0100100;
            4'd3: return 7'b0110000;
            4'd4: return 7'b0011001;
            4'd5: return 7'b0010010;
            4'd6: return 7'b0000010;
            4'd7: return 7'b1111000;
            4'd8: return 7'b0000000;
            4'd9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    task automatic expect_at(input string tag, input int sel, input int due, input logic [15:0] exp);
        exp_t e;
        e.tag = tag; e.sel = sel; e.due = due; e.exp = exp;
        sb_q.push_back(e);
    endtask

    always @(negedge clk_100MHz) begin
        for (int i = sb_q.size() - 1; i >= 0; i--) begin
            if (sb_q[i].due == cyc) begin
                chk(sb_q[i].tag, observe(sb_q[i].sel), sb_q[i].exp);
                sb_q.delete(i);
            end
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk_100MHz);
    endtask

    // Called at a negedge; the pulse is sampled at the following posedge.
    task automatic pulse(input int which);
        start_stop = (which == P_SS);
        lap        = (which == P_LAP) || (which == P_CLR_LAP);
        clear      = (which == P_CLR) || (which == P_CLR_LAP);
        @(negedge clk_100MHz);
        start_stop = 1'b0;
        lap        = 1'b0;
        clear      = 1'b0;
    endtask

    task automatic check_display(input string tag, input logic [15:0] val);
        logic [3:0] d;
        logic       ok;
        repeat (8) begin
            @(negedge clk_100MHz);
            ok = 1'b1;
            d  = 4'd0;
            case (digit_anodes)
                8'hFE: d = val[3:0];
                8'hFD: d = val[7:4];
                8'hFB: d = val[11:8];
                8'hF7: d = val[15:12];
                default: ok = 1'b0;
            endcase
            if (ok) chk(tag, {9'h0, digit_cathodes}, {9'h0, seg(d)});
            else    chk({tag, "_anode"}, {8'h0, digit_anodes}, 16'h00FE);
        end
    endtask

    task automatic reset_now(input string tag);
        #2 reset = 1'b0;
        #1;
        chk({tag, "_dig"},  digits, 16'h0000);
        chk({tag, "_an"},   {8'h0, digit_anodes}, 16'h00FE);
        chk({tag, "_ca"},   {9'h0, digit_cathodes}, 16'h0040);
        chk({tag, "_run"},  {15'h0, running}, 16'h0);
        chk({tag, "_done"}, {15'h0, done}, 16'h0);
        chk({tag, "_d1dig"}, d1_digits, 16'h0000);
        @(negedge clk_100MHz);
        reset = 1'b1;
        expect_at({tag, "_scan3"},  S_AN, cyc + 3,  16'h00FE);
        expect_at({tag, "_scan4"},  S_AN, cyc + 4,  16'h00FD);
        expect_at({tag, "_scan5"},  S_AN, cyc + 5,  16'h00FD);
        expect_at({tag, "_scan6"},  S_AN, cyc + 6,  16'h00FB);
        expect_at({tag, "_scan8"},  S_AN, cyc + 8,  16'h00F7);
        expect_at({tag, "_scan10"}, S_AN, cyc + 10, 16'h00FE);
        expect_at({tag, "_rdig"},   S_DIG, cyc + 3, 16'h0000);
        wait_cyc(12);
    endtask

    initial begin
        int c0;
        reset = 1'b1; start_stop = 1'b0; lap = 1'b0; clear = 1'b0;
        dir = 1'b0; preset = 16'h0000;
        wait_cyc(3);
        reset_now("por");

        // pause / resume keeps the divider residue
        c0 = cyc + 1;
        expect_at("p_run",   S_RUN, c0 + 1,  16'h1);
        expect_at("p_t4",    S_DIG, c0 + 49, 16'h0004);
        expect_at("p_t5",    S_DIG, c0 + 50, 16'h0005);
        pulse(P_SS);
        wait_cyc(54);
        expect_at("p_stop",  S_RUN, c0 + 55,  16'h0);
        expect_at("p_mid",   S_DIG, c0 + 80,  16'h0005);
        expect_at("p_hold",  S_DIG, c0 + 105, 16'h0005);
        pulse(P_SS);
        wait_cyc(50);
        check_display("p_disp", 16'h0005);
        c0 = cyc + 1;
        expect_at("r_pre",  S_DIG, c0 + 4, 16'h0005);
        expect_at("r_tick", S_DIG, c0 + 5, 16'h0006);
        pulse(P_SS);
        wait_cyc(6);
        expect_at("clr_dig", S_DIG, cyc + 1, 16'h0000);
        expect_at("clr_run", S_RUN, cyc + 1, 16'h0);
        pulse(P_CLR);
        wait_cyc(2);

        // lap hold freezes the display only
        c0 = cyc + 1;
        expect_at("l_023", S_DIG, c0 + 230, 16'h0023);
        pulse(P_SS);
        wait_cyc(230);
        expect_at("l_live", S_DIG, c0 + 250, 16'h0025);
        pulse(P_LAP);
        wait_cyc(20);
        check_display("l_snap", 16'h0023);
        pulse(P_LAP);
        wait_cyc(1);
        check_display("l_rest", 16'h0026);
        pulse(P_LAP);
        expect_at("cl_dig", S_DIG, cyc + 1, 16'h0000);
        expect_at("cl_run", S_RUN, cyc + 1, 16'h0);
        pulse(P_CLR_LAP);
        wait_cyc(1);
        check_display("cl_disp", 16'h0000);

        // down count and preset saturation
        dir = 1'b1; preset = 16'h0010;
        c0 = cyc + 1;
        expect_at("d_run",   S_RUN,  c0 + 1,   16'h1);
        expect_at("d_99",    S_DIG,  c0 + 99,  16'h0001);
        expect_at("d_99dn",  S_DONE, c0 + 99,  16'h0);
        expect_at("d_100dn", S_DONE, c0 + 100, 16'h1);
        expect_at("d_100",   S_DIG,  c0 + 100, 16'h0000);
        expect_at("d_100rn", S_RUN,  c0 + 100, 16'h0);
        pulse(P_SS);
        wait_cyc(105);
        pulse(P_CLR);
        preset = 16'h0000;
        expect_at("z_done", S_DONE, cyc + 1, 16'h1);
        expect_at("z_run",  S_RUN,  cyc + 1, 16'h0);
        pulse(P_SS);
        wait_cyc(3);
        pulse(P_CLR);
        preset = 16'hFFFF;
        expect_at("f_load", S_DIG, cyc + 1, 16'h9599);
        expect_at("f_run",  S_RUN, cyc + 1, 16'h1);
        pulse(P_SS);
        wait_cyc(3);
        pulse(P_CLR);
        preset = 16'h7A6C;
        expect_at("s_load", S_DIG, cyc + 1, 16'h7569);
        pulse(P_SS);
        wait_cyc(3);
        pulse(P_CLR);

        // long up count; dir changes after the start must be ignored
        dir = 1'b0;
        c0 = cyc + 1;
        expect_at("u_599",   S_DIG,    c0 + 5990,  16'h0599);
        expect_at("u_5999",  S_DIG,    c0 + 5999,  16'h0599);
        expect_at("u_1000",  S_DIG,    c0 + 6000,  16'h1000);
        expect_at("m_pre",   S_D1DIG,  c0 + 11989, 16'h1598);
        expect_at("m_predn", S_D1DONE, c0 + 11989, 16'h0);
        expect_at("m_done",  S_D1DONE, c0 + 11990, 16'h1);
        expect_at("m_dig",   S_D1DIG,  c0 + 11990, 16'h1599);
        expect_at("m_norun", S_D1RUN,  c0 + 11990, 16'h0);
        expect_at("u_1599",  S_DIG,    c0 + 11990, 16'h1599);
        expect_at("u_nodn",  S_DONE,   c0 + 11990, 16'h0);
        pulse(P_SS);
        dir = 1'b1;
        wait_cyc(11998);
        expect_at("m_hold",  S_D1DIG,  c0 + 12030, 16'h1599);
        expect_at("m_hdone", S_D1DONE, c0 + 12030, 16'h1);
        expect_at("u_pause", S_RUN,    c0 + 12030, 16'h0);
        pulse(P_SS);
        wait_cyc(31);
        pulse(P_CLR);
        wait_cyc(2);

        // asynchronous reset in the middle of a run
        dir = 1'b0;
        pulse(P_SS);
        wait_cyc(37);
        expect_at("mr_run", S_RUN, cyc + 1, 16'h1);
        wait_cyc(1);
        reset_now("mrst");

        for (int i = 0; i < 20 && sb_q.size() > 0; i++) wait_cyc(1);
        if (sb_q.size() > 0) chk("sb_drain", 16'(sb_q.size()), 16'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
